// File: rtl/out_fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// out_fifo_arbiter_pkg
//   Shared definitions for the output-FIFO write-port arbiter: controller state
//   encoding, header magic nibble, source index constants and the header byte
//   builder used when OUT_ARB_HEADER_EN is defined.
// -----------------------------------------------------------------------------
package out_fifo_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      XFER = 2'd2
   } arb_state_e;

   localparam logic [3:0] HDR_MAGIC = 4'hA;

   localparam int unsigned SRC_AUDIO  = 0;
   localparam int unsigned SRC_STATUS = 1;

   // Header byte that precedes a packet so the host can tell sources apart.
   function automatic logic [7:0] hdr_byte(input logic src);
      return {HDR_MAGIC, 3'b000, src};
   endfunction

endpackage

// File: rtl/out_fifo_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin pick. A lone requester is granted directly; on a
//   tie the source that was not served last wins.
// Ports:
//   req          in  2  request vector, bit i = source i
//   last_served  in  1  index of the source that owned the previous packet
//   grant        out 2  one-hot grant, 0 when nobody requests
// -----------------------------------------------------------------------------
module rr_arbiter2
   import out_fifo_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (&req) begin
         grant = '0;
         if (last_served == 1'(SRC_STATUS)) grant[SRC_AUDIO]  = 1'b1;
         else                               grant[SRC_STATUS] = 1'b1;
      end
   end

endmodule

// File: rtl/out_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// out_fifo_arbiter
//   Packet-atomic arbiter sharing the output async FIFO write port between the
//   audio control path (source 0) and the status path (source 1). Grants are
//   round-robin at packet boundaries; a packet that overruns MAX_PKT_BYTES or
//   idles STALL_CLKS cycles mid-packet is cut short and err_o is latched.
//   Optional build macro: OUT_ARB_HEADER_EN -- prefixes each packet with a
//   {4'hA, 3'b000, src} header byte.
// Ports:
//   clk_i               in  1     FIFO write-side clock
//   reset_n_i           in  1     synchronous active-low reset
//   src_valid_i         in  2     per-source byte valid
//   src_data_i          in  16    [7:0] source 0, [15:8] source 1
//   src_last_i          in  2     per-source last byte of packet
//   src_ready_o         out 2     per-source byte accepted when valid
//   wr_out_fifo_en_o    out 1     FIFO write strobe
//   wr_out_fifo_data_o  out 8     FIFO write data
//   wr_out_fifo_full_i  in  1     FIFO full
//   grant_o             out 2     one-hot current owner, 0 when idle
//   err_o               out 1     sticky overrun / stall-abort flag
// -----------------------------------------------------------------------------
module out_fifo_arbiter
   import out_fifo_arbiter_pkg::*;
#(
   parameter int unsigned MAX_PKT_BYTES = 256,
   parameter int unsigned STALL_CLKS    = 1024
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [1:0]  src_valid_i,
   input  logic [15:0] src_data_i,
   input  logic [1:0]  src_last_i,
   output logic [1:0]  src_ready_o,
   output logic        wr_out_fifo_en_o,
   output logic [7:0]  wr_out_fifo_data_o,
   input  logic        wr_out_fifo_full_i,
   output logic [1:0]  grant_o,
   output logic        err_o
);

   localparam int unsigned BYTE_W  = $clog2(MAX_PKT_BYTES);
   localparam int unsigned STALL_W = $clog2(STALL_CLKS + 1);

   arb_state_e         state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic [1:0]         rr_grant;
   logic               last_q, last_d;
   logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic               err_q, err_d;
   logic               owner;
   logic               accept;
   logic               end_pkt;

   assign owner   = grant_q[SRC_STATUS];
   assign grant_o = grant_q;
   assign err_o   = err_q;

   rr_arbiter2 u_rr (
      .req         (src_valid_i),
      .last_served (last_q),
      .grant       (rr_grant)
   );

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      last_d             = last_q;
      byte_cnt_d         = byte_cnt_q;
      stall_cnt_d        = stall_cnt_q;
      err_d              = err_q;
      src_ready_o        = '0;
      wr_out_fifo_en_o   = 1'b0;
      wr_out_fifo_data_o = '0;
      accept             = 1'b0;
      end_pkt            = 1'b0;

      case (state_q)
         IDLE: begin
            if (|src_valid_i) begin
               grant_d     = rr_grant;
               byte_cnt_d  = '0;
               stall_cnt_d = '0;
`ifdef OUT_ARB_HEADER_EN
               state_d     = HDR;
`else
               state_d     = XFER;
`endif
            end
         end

`ifdef OUT_ARB_HEADER_EN
         HDR: begin
            wr_out_fifo_en_o   = ~wr_out_fifo_full_i;
            wr_out_fifo_data_o = hdr_byte(owner);
            if (!wr_out_fifo_full_i) state_d = XFER;
         end
`endif

         XFER: begin
            // Full gates ready combinationally, so a write never lands on a full FIFO.
            src_ready_o[owner] = ~wr_out_fifo_full_i;
            accept             = src_valid_i[owner] & ~wr_out_fifo_full_i;
            wr_out_fifo_en_o   = accept;
            wr_out_fifo_data_o = src_data_i[{owner, 3'b000} +: 8];

            if (accept) begin
               byte_cnt_d  = byte_cnt_q + BYTE_W'(1);
               stall_cnt_d = '0;
               if (src_last_i[owner]) begin
                  end_pkt = 1'b1;
               end else if (byte_cnt_q == BYTE_W'(MAX_PKT_BYTES - 1)) begin
                  err_d   = 1'b1;
                  end_pkt = 1'b1;
               end
            end else if (!src_valid_i[owner]) begin
               // Back-pressure cycles (valid with full) are not counted as idle.
               if (stall_cnt_q != STALL_W'(STALL_CLKS))
                  stall_cnt_d = stall_cnt_q + STALL_W'(1);
               if (stall_cnt_q == STALL_W'(STALL_CLKS - 1)) begin
                  err_d   = 1'b1;
                  end_pkt = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      if (end_pkt) begin
         state_d = IDLE;
         grant_d = '0;
         last_d  = owner;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= 1'(SRC_STATUS);
         byte_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_out_fifo_arbiter
//   Directed and randomized bench for out_fifo_arbiter with MAX_PKT_BYTES=8 and
//   STALL_CLKS=16. Sources are modelled as queues of beats with idle gaps; the
//   FIFO side is a write log checked per source against the expected packet
//   streams, plus timing checks on bubbles, overrun and stall aborts.
// -----------------------------------------------------------------------------
module tb_out_fifo_arbiter;

   localparam int MAX_PKT = 8;
   localparam int STALL   = 16;
`ifdef OUT_ARB_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } beat_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] gnt;
      int         cyc;
   } wr_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n_i;
   logic [1:0]  src_valid_i;
   logic [15:0] src_data_i;
   logic [1:0]  src_last_i;
   logic [1:0]  src_ready_o;
   logic        wr_out_fifo_en_o;
   logic [7:0]  wr_out_fifo_data_o;
   logic        wr_out_fifo_full_i;
   logic [1:0]  grant_o;
   logic        err_o;

   always #5 clk = ~clk;

   out_fifo_arbiter #(
      .MAX_PKT_BYTES (MAX_PKT),
      .STALL_CLKS    (STALL)
   ) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n_i),
      .src_valid_i        (src_valid_i),
      .src_data_i         (src_data_i),
      .src_last_i         (src_last_i),
      .src_ready_o        (src_ready_o),
      .wr_out_fifo_en_o   (wr_out_fifo_en_o),
      .wr_out_fifo_data_o (wr_out_fifo_data_o),
      .wr_out_fifo_full_i (wr_out_fifo_full_i),
      .grant_o            (grant_o),
      .err_o              (err_o)
   );

   int    tests_run    = 0;
   int    tests_failed = 0;
   int    cyc          = 0;
   int    err_cyc      = -1;
   int    gap_cnt [2];
   logic  pkt_start [2];
   logic  full_drv     = 1'b0;
   logic  rst_drv      = 1'b0;
   logic [1:0] snap_grant, snap_ready;
   logic       snap_err, snap_en;

   beat_t src_q   [2][$];
   exp_t  exp_src [2][$];
   wr_t   log_q   [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      reset_n_i          = rst_drv;
      wr_out_fifo_full_i = full_drv;
      for (int s = 0; s < 2; s++) begin
         if (src_q[s].size() > 0 && gap_cnt[s] >= src_q[s][0].gap) begin
            src_valid_i[s]         = 1'b1;
            src_data_i[s*8 +: 8]   = src_q[s][0].data;
            src_last_i[s]          = src_q[s][0].last;
         end else begin
            src_valid_i[s]         = 1'b0;
            src_data_i[s*8 +: 8]   = 8'h00;
            src_last_i[s]          = 1'b0;
         end
      end
   endtask

   // One clock: drive, sample on the falling edge, then retire accepted beats.
   task automatic tick();
      logic [1:0] acc;
      wr_t        w;
      drive();
      @(negedge clk);
      snap_grant = grant_o;
      snap_err   = err_o;
      snap_en    = wr_out_fifo_en_o;
      snap_ready = src_ready_o;
      acc        = src_valid_i & src_ready_o;
      if (wr_out_fifo_en_o === 1'b1) begin
         w.data = wr_out_fifo_data_o;
         w.gnt  = grant_o;
         w.cyc  = cyc;
         log_q.push_back(w);
      end
      if (wr_out_fifo_full_i)
         check("write_while_full", 32'({src_ready_o, wr_out_fifo_en_o}), 32'd0);
      if (err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < 2; s++) begin
         if (acc[s] === 1'b1) begin
            void'(src_q[s].pop_front());
            gap_cnt[s] = 0;
         end else begin
            gap_cnt[s]++;
         end
      end
   endtask

   task automatic clear_sb();
      log_q.delete();
      for (int s = 0; s < 2; s++) begin
         src_q[s].delete();
         exp_src[s].delete();
         pkt_start[s] = 1'b1;
         gap_cnt[s]   = 0;
      end
   endtask

   task automatic do_reset();
      clear_sb();
      rst_drv = 1'b0;
      tick();
      rst_drv = 1'b1;
      err_cyc = -1;
   endtask

   // Queue a source beat and the FIFO bytes it is expected to produce.
   task automatic send(input int s, input logic [7:0] d, input logic last, input int gap);
      beat_t b;
      exp_t  e;
      b.data = d;
      b.last = last;
      b.gap  = gap;
      src_q[s].push_back(b);
`ifdef OUT_ARB_HEADER_EN
      if (pkt_start[s]) begin
         e.data = 8'hA0 | 8'(s);
         e.last = 1'b0;
         exp_src[s].push_back(e);
      end
`endif
      e.data = d;
      e.last = last;
      exp_src[s].push_back(e);
      pkt_start[s] = last;
   endtask

   // The arbiter cuts the packet here (overrun or stall).
   task automatic exp_break(input int s);
      exp_t e;
      e = exp_src[s].pop_back();
      e.last = 1'b1;
      exp_src[s].push_back(e);
      pkt_start[s] = 1'b1;
   endtask

   task automatic drain(input int bound, input int extra);
      int n = 0;
      while ((src_q[0].size() + src_q[1].size()) > 0 && n < bound) begin
         tick();
         n++;
      end
      check("drain_in_time", 32'(src_q[0].size() + src_q[1].size()), 32'd0);
      repeat (extra) tick();
   endtask

   // Split the write log by owner, compare to each source's expected stream and
   // require that ownership only changes right after a packet end.
   task automatic check_walk(input string tag);
      int         idx [2];
      int         cnt [2];
      int         s;
      logic       prev_last;
      logic [1:0] prev_g;
      exp_t       e;
      idx[0] = 0; idx[1] = 0; cnt[0] = 0; cnt[1] = 0;
      prev_last = 1'b1;
      prev_g    = 2'b00;
      foreach (log_q[i]) begin
         s = log_q[i].gnt[1] ? 1 : 0;
         check({tag, "_onehot"}, 32'($onehot(log_q[i].gnt)), 32'd1);
         cnt[s]++;
         if (idx[s] < exp_src[s].size()) begin
            e = exp_src[s][idx[s]];
            check({tag, "_data"}, 32'(log_q[i].data), 32'(e.data));
            if (log_q[i].gnt != prev_g)
               check({tag, "_no_interleave"}, 32'(prev_last), 32'd1);
            prev_last = e.last;
            prev_g    = log_q[i].gnt;
            idx[s]++;
         end
      end
      check({tag, "_src0_count"}, 32'(cnt[0]), 32'(exp_src[0].size()));
      check({tag, "_src1_count"}, 32'(cnt[1]), 32'(exp_src[1].size()));
   endtask

   initial begin
      src_valid_i        = '0;
      src_data_i         = '0;
      src_last_i         = '0;
      wr_out_fifo_full_i = 1'b0;
      reset_n_i          = 1'b0;

      // Reset state
      do_reset();
      tick();
      check("rst_grant", 32'(snap_grant), 32'd0);
      check("rst_err",   32'(snap_err),   32'd0);
      check("rst_en",    32'(snap_en),    32'd0);
      check("rst_ready", 32'(snap_ready), 32'd0);

      // Basic 4-byte packet from source 0
      clear_sb();
      send(0, 8'h11, 1'b0, 0);
      send(0, 8'h22, 1'b0, 0);
      send(0, 8'h33, 1'b0, 0);
      send(0, 8'h44, 1'b1, 0);
      drain(20, 3);
      check_walk("basic");
      for (int i = 0; i < 3; i++)
         check("basic_consecutive", 32'(log_q[HDR+i+1].cyc - log_q[HDR+i].cyc), 32'd1);
      check("basic_grant_idle", 32'(snap_grant), 32'd0);
      check("basic_no_err", 32'(err_cyc), 32'hFFFF_FFFF);

      // Both sources stream 2-byte packets: strict alternation with a bubble
      do_reset();
      for (int k = 0; k < 2; k++) begin
         send(0, 8'h31 + 8'(2*k), 1'b0, 0);
         send(0, 8'h32 + 8'(2*k), 1'b1, 0);
         send(1, 8'h41 + 8'(2*k), 1'b0, 0);
         send(1, 8'h42 + 8'(2*k), 1'b1, 0);
      end
      drain(40, 2);
      check_walk("alt");
      for (int k = 0; k < 4; k++)
         check("alt_grant_order", 32'(log_q[k*(2+HDR)].gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      for (int k = 0; k < 3; k++)
         check("alt_bubble", 32'(log_q[(k+1)*(2+HDR)].cyc - log_q[k*(2+HDR)+1+HDR].cyc), 32'd2);

      // FIFO full for 3 cycles mid-packet
      clear_sb();
      for (int i = 0; i < 6; i++) send(0, 8'hC1 + 8'(i), (i == 5), 0);
      for (int n = 0; n < 20 && log_q.size() < 2 + HDR; n++) tick();
      full_drv = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("full_en_low",    32'(snap_en),    32'd0);
         check("full_ready_low", 32'(snap_ready), 32'd0);
      end
      full_drv = 1'b0;
      check("full_no_extra_write", 32'(log_q.size()), 32'(2 + HDR));
      drain(20, 2);
      check_walk("full");
      check("full_no_err", 32'(snap_err), 32'd0);

      // Overrun: source 1 sends 10 bytes without last
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send(1, 8'h80 + 8'(i), 1'b0, 0);
         if (i == MAX_PKT - 1) exp_break(1);
      end
      exp_break(1);
      drain(40, STALL + 4);
      check_walk("ovr");
      check("ovr_err_after_8th", 32'(err_cyc), 32'(log_q[HDR+MAX_PKT-1].cyc + 1));
      check("ovr_bubble", 32'(log_q[HDR+MAX_PKT].cyc - log_q[HDR+MAX_PKT-1].cyc), 32'd2);
      check("ovr_idle", 32'(snap_grant), 32'd0);

      // Stall boundary: 15 idle cycles mid-packet is tolerated
      do_reset();
      send(0, 8'h51, 1'b0, 0);
      send(0, 8'h52, 1'b1, STALL - 1);
      drain(60, 2);
      check_walk("stall15");
      check("stall15_gap", 32'(log_q[HDR+1].cyc - log_q[HDR].cyc), 32'(STALL));
      check("stall15_no_err", 32'(err_cyc), 32'hFFFF_FFFF);

      // Stall abort after 16 idle cycles, pending source 1 granted next
      do_reset();
      send(0, 8'h51, 1'b0, 0);
      send(0, 8'h52, 1'b0, 0);
      exp_break(0);
      send(1, 8'h61, 1'b0, 0);
      send(1, 8'h62, 1'b1, 0);
      send(0, 8'h53, 1'b1, STALL + 9);
      drain(100, 2);
      check_walk("stall");
      check("stall_err", 32'(snap_err), 32'd1);
      check("stall_err_time", 32'(err_cyc), 32'(log_q[HDR+1].cyc + STALL + 1));
      check("stall_next_owner", 32'(log_q[HDR+2].gnt), 32'd2);
      check("stall_next_time", 32'(log_q[HDR+2].cyc - log_q[HDR+1].cyc), 32'(STALL + 2));

      // Reset mid-packet drops ownership; source 0 wins the next tie
      clear_sb();
      for (int i = 0; i < 4; i++) send(0, 8'hA1 + 8'(i), (i == 3), 0);
      repeat (3) tick();
      do_reset();
      tick();
      check("midrst_grant", 32'(snap_grant), 32'd0);
      check("midrst_en",    32'(snap_en),    32'd0);
      check("midrst_ready", 32'(snap_ready), 32'd0);
      check("midrst_err",   32'(snap_err),   32'd0);
      send(0, 8'hB1, 1'b1, 0);
      send(1, 8'hC1, 1'b1, 0);
      drain(20, 2);
      check("midrst_first_tie", 32'(log_q[0].gnt), 32'd1);
      check_walk("midrst");

      // Randomized traffic with random gaps and FIFO back-pressure
      do_reset();
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 25; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++)
               send(s, 8'($urandom), (i == len - 1), int'($urandom_range(0, 3)));
         end
      end
      for (int n = 0; n < 3000 && (src_q[0].size() + src_q[1].size()) > 0; n++) begin
         full_drv = ($urandom_range(0, 3) == 0);
         tick();
      end
      full_drv = 1'b0;
      drain(10, 3);
      check_walk("rand");
      check("rand_no_err", 32'(snap_err), 32'd0);
      check("rand_idle",   32'(snap_grant), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
